// File: rtl/clk_div_pkg.sv
// clk_div_pkg
// Shared constants and a helper function for the clock-divider bank.
//   CH_IDX_W        : width of the configuration channel index
//   MAX_CH          : largest channel count the index can address
//   CNT_W_DEFAULT   : default divisor/counter width
//   DEF_DIV_DEFAULT : default divisor loaded into every channel at reset
package clk_div_pkg;

    localparam int CH_IDX_W        = 4;
    localparam int MAX_CH          = 16;
    localparam int CNT_W_DEFAULT   = 8;
    localparam int DEF_DIV_DEFAULT = 1;

    // True when a configuration index addresses a channel that exists.
    function automatic logic ch_in_range(input logic [CH_IDX_W-1:0] idx,
                                         input int num_ch);
        return (int'(idx) < num_ch);
    endfunction

endpackage

// File: rtl/clk_div_ch.sv
// clk_div_ch
// One divided-clock channel: counter, output toggle flop, tick pulse and
// active divisor. Output period is 2*(div+1) input clocks.
// Build option: CLK_DIV_GLITCHFREE_EN
//   defined   : writes go to a shadow register and are adopted at the next
//               falling edge of clk_out (or at once when the channel is off)
//   undefined : writes load the active divisor on the accepting edge
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   en        : run enable for this channel
//   wr_en     : accepted divisor write targeting this channel
//   wr_div    : divisor value for the write
//   clk_out   : registered divided clock
//   tick      : one-cycle pulse in the cycle clk_out rises
//   pending   : (CLK_DIV_GLITCHFREE_EN only) shadow divisor awaiting adoption
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEFAULT,
    parameter int DEF_DIV = DEF_DIV_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_div,
    output logic             clk_out,
`ifdef CLK_DIV_GLITCHFREE_EN
    output logic             pending,
`endif
    output logic             tick
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             wrap;

    // >= rather than == so a divisor written below the running count
    // forces an immediate toggle-and-clear instead of a counter wrap.
    assign wrap = (cnt_q >= div_q);

`ifdef CLK_DIV_GLITCHFREE_EN
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             pend_q, pend_d;
    logic             fall;

    // Falling edge of clk_out is the period boundary where a new divisor
    // can be adopted without shortening a half-period.
    assign fall    = en & wrap & clk_out_q;
    assign pending = pend_q;
`endif

    always_comb begin
        cnt_d     = cnt_q;
        clk_out_d = clk_out_q;
        tick_d    = 1'b0;
        div_d     = div_q;
        if (!en) begin
            cnt_d     = '0;
            clk_out_d = 1'b0;
        end else if (wrap) begin
            cnt_d     = '0;
            clk_out_d = ~clk_out_q;
            tick_d    = ~clk_out_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
`ifdef CLK_DIV_GLITCHFREE_EN
        shadow_d = shadow_q;
        pend_d   = pend_q;
        if (wr_en) begin
            // An idle channel has no period to protect, so take it at once.
            if (!en) begin
                div_d = wr_div;
            end else begin
                shadow_d = wr_div;
                pend_d   = 1'b1;
            end
        end else if (pend_q && (!en || fall)) begin
            div_d  = shadow_q;
            pend_d = 1'b0;
        end
`else
        if (wr_en) begin
            div_d = wr_div;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            div_q     <= CNT_W'(DEF_DIV);
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

`ifdef CLK_DIV_GLITCHFREE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= CNT_W'(DEF_DIV);
            pend_q   <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
        end
    end
`endif

    assign clk_out = clk_out_q;
    assign tick    = tick_q;

endmodule

// File: rtl/clk_div_bank.sv
// clk_div_bank
// Bank of NUM_CH independent clock dividers with a valid/ready divisor
// write port. Writes to a nonexistent channel are accepted, change nothing,
// and raise cfg_err for one cycle.
// Build option: CLK_DIV_GLITCHFREE_EN
//   defined   : divisor updates are deferred to a period boundary and
//               cfg_ready drops while any channel holds a pending update
//   undefined : divisor updates apply immediately, cfg_ready is always 1
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   en        : per-channel run enable
//   cfg_valid, cfg_ch, cfg_div, cfg_ready : divisor write handshake
//   cfg_err   : one-cycle pulse on an accepted write to a bad channel
//   clk_out   : divided clocks, 50% duty
//   tick      : per-channel pulse on each clk_out rising edge
//   dummy_out : toggles every cycle while any channel is enabled
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = CNT_W_DEFAULT,
    parameter int DEF_DIV = DEF_DIV_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_CH-1:0]   en,
    input  logic                cfg_valid,
    input  logic [CH_IDX_W-1:0] cfg_ch,
    input  logic [CNT_W-1:0]    cfg_div,
    output logic                cfg_ready,
    output logic                cfg_err,
    output logic [NUM_CH-1:0]   clk_out,
    output logic [NUM_CH-1:0]   tick,
    output logic                dummy_out
);

    logic              cfg_fire;
    logic [NUM_CH-1:0] wr_sel;
    logic              cfg_err_q, cfg_err_d;
    logic              dummy_q, dummy_d;

    assign cfg_fire = cfg_valid & cfg_ready;

    // Decode by comparison so an out-of-range index selects no channel.
    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_sel[i] = cfg_fire && (int'(cfg_ch) == i);
        end
    end

    always_comb begin
        cfg_err_d = cfg_fire & ~ch_in_range(cfg_ch, NUM_CH);
        dummy_d   = (|en) ? ~dummy_q : dummy_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_err_q <= 1'b0;
            dummy_q   <= 1'b1;
        end else begin
            cfg_err_q <= cfg_err_d;
            dummy_q   <= dummy_d;
        end
    end

`ifdef CLK_DIV_GLITCHFREE_EN
    logic [NUM_CH-1:0] pending;
    assign cfg_ready = ~|pending;
`else
    assign cfg_ready = 1'b1;
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clk_div_ch #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .en      (en[g]),
            .wr_en   (wr_sel[g]),
            .wr_div  (cfg_div),
            .clk_out (clk_out[g]),
`ifdef CLK_DIV_GLITCHFREE_EN
            .pending (pending[g]),
`endif
            .tick    (tick[g])
        );
    end

    assign cfg_err   = cfg_err_q;
    assign dummy_out = dummy_q;

endmodule

// File: tb/tb_clk_div_bank.sv
// tb_clk_div_bank
// Directed testbench for clk_div_bank (NUM_CH=4, CNT_W=8, DEF_DIV=1).
// Expectations follow CLK_DIV_GLITCHFREE_EN when it is defined.
module tb_clk_div_bank;

`ifdef CLK_DIV_GLITCHFREE_EN
    localparam bit GF = 1'b1;
`else
    localparam bit GF = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [3:0] en;
    logic       cfg_valid;
    logic [3:0] cfg_ch;
    logic [7:0] cfg_div;
    logic       cfg_ready;
    logic       cfg_err;
    logic [3:0] clk_out;
    logic [3:0] tick;
    logic       dummy_out;

    int vectors;
    int miscompares;
    logic dummy_model;

    clk_div_bank #(
        .NUM_CH  (4),
        .CNT_W   (8),
        .DEF_DIV (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .clk_out   (clk_out),
        .tick      (tick),
        .dummy_out (dummy_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n edges, sampling 1 time unit after each edge; the dummy_out
    // reference flips whenever an enable is seen at the edge.
    task automatic step(input int n);
        repeat (n) begin
            if (|en) dummy_model = ~dummy_model;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; en = '0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;
        dummy_model = 1'b1;
        #12;
        vectors++;
        if (clk_out !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL reset_clk_out: got %b expected %b", clk_out, 4'b0000);
        end
        vectors++;
        if (tick !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL reset_tick: got %b expected %b", tick, 4'b0000);
        end
        vectors++;
        if (cfg_err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_cfg_err: got %b expected 0", cfg_err);
        end
        vectors++;
        if (dummy_out !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_dummy: got %b expected 1", dummy_out);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if (cfg_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_ready: got %b expected 1", cfg_ready);
        end
        step(2);
        vectors++;
        if (dummy_out !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL idle_dummy_hold: got %b expected 1", dummy_out);
        end
        vectors++;
        if (clk_out !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL idle_clk_out: got %b expected 0000", clk_out);
        end
    endtask

    task automatic test_ch0_default;
        logic [3:0] exp_out, exp_tick;
        en = 4'b0001;
        for (int k = 1; k <= 16; k++) begin
            step(1);
            exp_out  = {3'b000, ((k / 2) % 2) == 1};
            exp_tick = {3'b000, (k % 4) == 2};
            vectors++;
            if (clk_out !== exp_out) begin
                miscompares++;
                $display("[TB] FAIL ch0_clk_out edge %0d: got %b expected %b", k, clk_out, exp_out);
            end
            vectors++;
            if (tick !== exp_tick) begin
                miscompares++;
                $display("[TB] FAIL ch0_tick edge %0d: got %b expected %b", k, tick, exp_tick);
            end
            vectors++;
            if (dummy_out !== dummy_model) begin
                miscompares++;
                $display("[TB] FAIL ch0_dummy edge %0d: got %b expected %b", k, dummy_out, dummy_model);
            end
        end
    endtask

    task automatic test_fast_ch2;
        logic [3:0] exp_out;
        en = '0;
        step(1);
        cfg_valid = 1'b1; cfg_ch = 4'd2; cfg_div = 8'd0;
        step(1);
        cfg_valid = 1'b0;
        vectors++;
        if (cfg_err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL ch2_write_err: got %b expected 0", cfg_err);
        end
        en = 4'b0100;
        for (int k = 1; k <= 8; k++) begin
            step(1);
            exp_out = {1'b0, (k % 2) == 1, 2'b00};
            vectors++;
            if (clk_out !== exp_out) begin
                miscompares++;
                $display("[TB] FAIL ch2_clk_out edge %0d: got %b expected %b", k, clk_out, exp_out);
            end
            vectors++;
            if (tick !== exp_out) begin
                miscompares++;
                $display("[TB] FAIL ch2_tick edge %0d: got %b expected %b", k, tick, exp_out);
            end
            vectors++;
            if (dummy_out !== dummy_model) begin
                miscompares++;
                $display("[TB] FAIL ch2_dummy edge %0d: got %b expected %b", k, dummy_out, dummy_model);
            end
        end
    endtask

    task automatic test_bad_channel;
        logic [3:0] bad_ch [3];
        logic [3:0] exp_out [3];
        logic [3:0] exp_tick [3];
        bad_ch = '{4'd4, 4'd5, 4'd15};
        exp_out  = '{4'b0100, 4'b1011, 4'b1111};
        exp_tick = '{4'b0100, 4'b1011, 4'b0100};
        en = '0;
        step(1);
        for (int i = 0; i < 3; i++) begin
            cfg_valid = 1'b1; cfg_ch = bad_ch[i]; cfg_div = 8'd3;
            step(1);
            cfg_valid = 1'b0;
            vectors++;
            if (cfg_err !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL bad_ch%0d_err_pulse: got %b expected 1", bad_ch[i], cfg_err);
            end
            step(1);
            vectors++;
            if (cfg_err !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL bad_ch%0d_err_clear: got %b expected 0", bad_ch[i], cfg_err);
            end
        end
        // Divisors still 1,1,0,1: ch2 rises first, the rest one edge later.
        en = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            step(1);
            vectors++;
            if (clk_out !== exp_out[k]) begin
                miscompares++;
                $display("[TB] FAIL bad_ch_divs_clk_out edge %0d: got %b expected %b", k + 1, clk_out, exp_out[k]);
            end
            vectors++;
            if (tick !== exp_tick[k]) begin
                miscompares++;
                $display("[TB] FAIL bad_ch_divs_tick edge %0d: got %b expected %b", k + 1, tick, exp_tick[k]);
            end
        end
    endtask

    task automatic test_retime;
        int   fall_edge;
        logic eo, et, er;
        fall_edge = GF ? 16 : 15;
        en = '0;
        step(1);
        cfg_valid = 1'b1; cfg_ch = 4'd0; cfg_div = 8'd7;
        step(1);
        cfg_valid = 1'b0;
        en = 4'b0001;
        for (int k = 1; k <= 26; k++) begin
            step(1);
            if (k < 8)              eo = 1'b0;
            else if (k < fall_edge) eo = 1'b1;
            else                    eo = (((k - fall_edge) / 3) % 2) == 1;
            et = (k == 8) || (k >= fall_edge && ((k - fall_edge) % 6) == 3);
            er = !(GF && (k == 14 || k == 15));
            vectors++;
            if (clk_out !== {3'b000, eo}) begin
                miscompares++;
                $display("[TB] FAIL retime_clk_out edge %0d: got %b expected %b", k, clk_out, {3'b000, eo});
            end
            vectors++;
            if (tick !== {3'b000, et}) begin
                miscompares++;
                $display("[TB] FAIL retime_tick edge %0d: got %b expected %b", k, tick, {3'b000, et});
            end
            vectors++;
            if (cfg_ready !== er) begin
                miscompares++;
                $display("[TB] FAIL retime_ready edge %0d: got %b expected %b", k, cfg_ready, er);
            end
            if (k == 13) begin
                cfg_valid = 1'b1; cfg_ch = 4'd0; cfg_div = 8'd2;
            end else begin
                cfg_valid = 1'b0;
            end
        end
    endtask

    task automatic test_drop_reenable;
        logic eo, et;
        en = '0;
        step(1);
        en = 4'b0010;
        for (int k = 1; k <= 3; k++) begin
            step(1);
            eo = (k >= 2);
            et = (k == 2);
            vectors++;
            if (clk_out !== {2'b00, eo, 1'b0} || tick !== {2'b00, et, 1'b0}) begin
                miscompares++;
                $display("[TB] FAIL ch1_run edge %0d: got out=%b tick=%b expected out=%b tick=%b",
                         k, clk_out, tick, {2'b00, eo, 1'b0}, {2'b00, et, 1'b0});
            end
        end
        // Disable mid high phase together with a divisor write.
        en = '0;
        cfg_valid = 1'b1; cfg_ch = 4'd1; cfg_div = 8'd3;
        step(1);
        cfg_valid = 1'b0;
        vectors++;
        if (clk_out !== 4'b0000 || tick !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL ch1_drop: got out=%b tick=%b expected out=0000 tick=0000", clk_out, tick);
        end
        vectors++;
        if (cfg_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL ch1_drop_ready: got %b expected 1", cfg_ready);
        end
        step(2);
        vectors++;
        if (clk_out !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL ch1_idle: got %b expected 0000", clk_out);
        end
        en = 4'b0010;
        for (int k = 1; k <= 6; k++) begin
            step(1);
            eo = (k >= 4);
            et = (k == 4);
            vectors++;
            if (clk_out !== {2'b00, eo, 1'b0} || tick !== {2'b00, et, 1'b0}) begin
                miscompares++;
                $display("[TB] FAIL ch1_reenable edge %0d: got out=%b tick=%b expected out=%b tick=%b",
                         k, clk_out, tick, {2'b00, eo, 1'b0}, {2'b00, et, 1'b0});
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [3:0] exp_out, exp_tick;
        en = '0;
        step(1);
        en = 4'b0001;
        step(4);
        cfg_valid = 1'b1; cfg_ch = 4'd0; cfg_div = 8'd5;
        step(1);
        cfg_valid = 1'b0;
        vectors++;
        if (cfg_ready !== !GF) begin
            miscompares++;
            $display("[TB] FAIL midrst_pending_ready: got %b expected %b", cfg_ready, !GF);
        end
        #2;
        rst = 1'b1;
        en = '0;
        dummy_model = 1'b1;
        #1;
        vectors++;
        if (clk_out !== 4'b0000 || tick !== 4'b0000 || cfg_err !== 1'b0 || dummy_out !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL midrst_outputs: got out=%b tick=%b err=%b dummy=%b expected 0000 0000 0 1",
                     clk_out, tick, cfg_err, dummy_out);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if (cfg_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL midrst_ready: got %b expected 1", cfg_ready);
        end
        step(1);
        // Divisor back to DEF_DIV=1: period 4, not 6 or 12.
        en = 4'b0001;
        for (int k = 1; k <= 8; k++) begin
            step(1);
            exp_out  = {3'b000, ((k / 2) % 2) == 1};
            exp_tick = {3'b000, (k % 4) == 2};
            vectors++;
            if (clk_out !== exp_out || tick !== exp_tick) begin
                miscompares++;
                $display("[TB] FAIL midrst_period edge %0d: got out=%b tick=%b expected out=%b tick=%b",
                         k, clk_out, tick, exp_out, exp_tick);
            end
            vectors++;
            if (dummy_out !== dummy_model) begin
                miscompares++;
                $display("[TB] FAIL midrst_dummy edge %0d: got %b expected %b", k, dummy_out, dummy_model);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_ch0_default();
        test_fast_ch2();
        test_bad_channel();
        test_retime();
        test_drop_reenable();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/clk_div_bank.md
CLK_DIV_BANK -- requirements
Module: clk_div_bank

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4: number of divided-clock channels, 1..16.
REQ-002 The block SHALL have parameter CNT_W, default 8: divisor/counter width, 2..16.
REQ-003 The block SHALL have parameter DEF_DIV, default 1: divisor loaded into every channel at reset.
REQ-004 Port clk  input  1  sole clock; all state on posedge clk.
REQ-005 Port rst  input  1  asynchronous, active-high reset.
REQ-006 Port en  input  NUM_CH  per-channel run enable.
REQ-007 Port cfg_valid  input  1  divisor-write request.
REQ-008 Port cfg_ch  input  4  target channel index.
REQ-009 Port cfg_div  input  CNT_W  new divisor value.
REQ-010 Port cfg_ready  output  1  write accepted when cfg_valid & cfg_ready.
REQ-011 Port cfg_err  output  1  one-cycle pulse on accepted write with cfg_ch >= NUM_CH.
REQ-012 Port clk_out  output  NUM_CH  registered divided clocks, 50% duty.
REQ-013 Port tick  output  NUM_CH  one-cycle pulse per channel on each clk_out rising edge.
REQ-014 Port dummy_out  output  1  toggles every clk cycle while any en bit is set.

Function
REQ-015 Each channel SHALL hold a counter cnt (CNT_W bits) and an active divisor div_q.
REQ-016 With en[i]=1: if cnt==div_q, clk_out[i] SHALL toggle and cnt clear to 0; else cnt increments by 1.
REQ-017 clk_out period SHALL be 2*(div_q+1) clk cycles; div_q=0 gives clk/2.
REQ-018 tick[i] SHALL be 1 in the cycle clk_out[i] goes 0->1 (same edge, registered), 0 otherwise.
REQ-019 With en[i]=0: cnt SHALL be forced to 0, clk_out[i] to 0, tick[i] to 0 on the next edge.
REQ-020 On en[i] 0->1: first clk_out[i] rise SHALL occur div_q+1 cycles after the enabling edge.
REQ-021 Counter SHALL never wrap: writing a div below current cnt forces toggle-and-clear on next edge.
REQ-022 Accepted write with cfg_ch >= NUM_CH SHALL change no state and assert cfg_err for one cycle.
REQ-023 Simultaneous write and en[i] falling SHALL apply the new divisor and clear the channel.
REQ-024 dummy_out SHALL hold value when all en bits are 0.

Reset
REQ-025 While rst=1: clk_out=0, tick=0, cfg_err=0, dummy_out=1, all cnt=0, all div_q=DEF_DIV, pending flags=0.
REQ-026 cfg_ready SHALL be 1 immediately after reset deassertion.
REQ-027 Reset mid-period SHALL discard the period and any pending divisor.

Configuration
REQ-028 Macro CLK_DIV_GLITCHFREE_EN SHALL select update timing.
REQ-029 Defined: write lands in shadow register; div_q takes it at the next toggle-to-0 edge (or immediately if en[i]=0); cfg_ready=0 while any shadow is pending.
REQ-030 Undefined: write loads div_q on the accepting edge; cfg_ready tied to 1.

Structure
REQ-031 Package clk_div_pkg SHALL hold CH_IDX_W=4, MAX_CH=16 and the default CNT_W/DEF_DIV constants.
REQ-032 Per-channel counter/toggle/shadow logic SHALL live in sub-module clk_div_ch, generated NUM_CH times.

Verification (NUM_CH=4, CNT_W=8, DEF_DIV=1)
REQ-033 Reset, en=4'b0001, run 16 cycles -> clk_out[0] period 4, tick[0] every 4th cycle, first rise 2 cycles after enable.
REQ-034 Write ch2 div=0, en[2]=1 -> clk_out[2] toggles every cycle, period 2; dummy_out toggles every cycle.
REQ-035 Write ch5 div=3 -> cfg_err=1 for one cycle; all div_q unchanged.
REQ-036 ch0 running div=7, write div=2 at cnt=5 -> with macro: old period finishes, then period 6; without macro: toggle on next edge, then period 6.
REQ-037 Drop en[1] mid-period -> clk_out[1]=0 next edge; re-enable -> first rise after div_q+1 cycles.
REQ-038 Assert rst mid-run with pending shadow write -> all outputs at reset values, pending write lost, cfg_ready=1 after release.
